mm_bus_master: RTL
==================

Name: mm_bus_master

Overview:
- Initiator side of the shared memory-mapped peripheral bus.
- Accepts single read/write requests from the CPU load/store path and drives the bus strobes, address and write data. Responders answer with ack and read data.
- Waits for ack, then returns read data or an error to the requester.
- Bounds every access with a timeout, so an unmapped address (no responder drives ack) cannot hang the core.

Parameters:
TIMEOUT_CYCLES, 16, number of bus cycles with strobe asserted and no ack before the access is aborted (legal range 1..255)
ERR_DATA, 32'h0000_0000, value returned on resp_rdata_o for a timed-out read

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
req_valid_i  input  1  request present
req_ready_o  output  1  master can accept a request this cycle
req_we_i  input  1  1=write, 0=read
req_addr_i  input  32  byte address
req_wdata_i  input  32  write data
resp_valid_o  output  1  response present
resp_ready_i  input  1  requester accepts response
resp_rdata_o  output  32  read data (0 for writes)
resp_err_o  output  1  access timed out
err_count_o  output  8  saturating count of timed-out accesses
bus_write_o  output  1  bus write strobe
bus_read_o  output  1  bus read strobe
bus_addr_o  output  32  bus address
bus_wdata_o  output  32  bus write data
bus_rdata_i  input  32  bus read data (resolved tri-state)
bus_ack_i  input  1  bus ack (resolved tri-state)

Behaviour:
Interface:
- One clock, clk.
- Reset rst_n is synchronous and active-low: sampled only on posedge clk.

Reset values:
- State IDLE.
- req_ready_o=1.
- resp_valid_o=0, resp_err_o=0, resp_rdata_o=0.
- err_count_o=0.
- All bus_* outputs 0.
- Timeout counter 0.
- Reset asserted mid-access aborts it: strobes low on the next edge, no response is produced, err_count_o is not incremented.

State machine:
- IDLE:
  - req_ready_o=1, bus strobes 0.
  - On req_valid_i: register addr, wdata and we onto bus_addr_o/bus_wdata_o; set exactly one of bus_write_o or bus_read_o; clear the counter; go to BUS.
- BUS:
  - req_ready_o=0, strobe held, address and data stable.
  - Sample bus_ack_i each cycle. Only a clean 1 counts as ack; z or x counts as no ack.
  - Ack on a read: capture bus_rdata_i into resp_rdata_o.
  - Ack on a write: resp_rdata_o=0.
  - On ack: resp_err_o=0, drop strobes, go to RESP.
  - No ack: increment counter. When the counter reaches TIMEOUT_CYCLES-1 without ack:
    - drop strobes, resp_err_o=1, resp_rdata_o=ERR_DATA for reads (0 for writes);
    - err_count_o += 1, saturating at 255;
    - go to RESP.
- RESP:
  - resp_valid_o=1; outputs held stable while resp_ready_i=0.
  - On resp_ready_i: resp_valid_o=0, go to IDLE. No new request is accepted in the same cycle.

Timing and ordering:
- Latency with an immediate (combinational) ack:
  - request accepted at edge N;
  - strobe high during cycle N+1;
  - resp_valid_o high from edge N+2.
  - Best-case throughput is one access per 3 cycles.
- Strobe asserted for at most TIMEOUT_CYCLES consecutive cycles per access.
- Never more than one outstanding access; bus_read_o and bus_write_o are never both 1.
- bus_addr_o and bus_wdata_o hold their last values while idle; only the strobes qualify them.
- An ack arriving in the same cycle the timeout would fire wins: no error is reported.

Test Plan:
- Write 0x000003FF to 0x4000_0000 with a responder that acks combinationally -> bus_write_o high exactly one cycle (N+1); resp_valid_o at N+2, resp_err_o=0, resp_rdata_o=0; req_ready_o low from N+1 until the response is accepted.
- Read 0x4000_0000 with the responder returning 0x00000155 after 3 wait cycles -> bus_read_o high 4 cycles; resp_rdata_o=0x00000155, resp_err_o=0.
- Read unmapped 0x5000_0000 (ack floats z), TIMEOUT_CYCLES=16 -> bus_read_o high exactly 16 cycles; resp_err_o=1, resp_rdata_o=ERR_DATA, err_count_o 0->1.
- Hold resp_ready_i=0 for 5 cycles after a read of 0x155 -> resp_valid_o, resp_rdata_o and resp_err_o stable; req_ready_o=0 throughout; back to IDLE one cycle after resp_ready_i=1.
- Assert rst_n=0 during BUS on the 3rd strobe cycle -> at the next edge strobes=0, req_ready_o=1, resp_valid_o=0, err_count_o unchanged.
- Issue 260 back-to-back timed-out writes -> err_count_o saturates at 255; ack coinciding with the final timeout cycle -> resp_err_o=0, counter unchanged.

Source files
------------

// File: rtl/mm_bus_master.sv
// Initiator for the shared memory-mapped peripheral bus: one outstanding access,
// strobe held until ack or timeout, then the response is held until accepted.
module mm_bus_master #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [7:0]  err_count_o,
  output logic        bus_write_o,
  output logic        bus_read_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] tmo_cnt;
  logic       ack;
  logic       timeout;

  // A floating (z/x) ack never evaluates true, so only a clean 1 completes.
  assign ack     = (bus_ack_i == 1'b1);
  assign timeout = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nx = BUS;
      end
      BUS: begin
        if (ack || timeout) state_nx = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt      <= '0;
      bus_write_o  <= 1'b0;
      bus_read_o   <= 1'b0;
      bus_addr_o   <= '0;
      bus_wdata_o  <= '0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
      err_count_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            bus_addr_o  <= req_addr_i;
            bus_wdata_o <= req_wdata_i;
            bus_write_o <= req_we_i;
            bus_read_o  <= !req_we_i;
            tmo_cnt     <= '0;
          end
        end
        BUS: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (ack) begin
            bus_write_o  <= 1'b0;
            bus_read_o   <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= bus_read_o ? bus_rdata_i : 32'h0;
          end else if (timeout) begin
            bus_write_o  <= 1'b0;
            bus_read_o   <= 1'b0;
            resp_err_o   <= 1'b1;
            resp_rdata_o <= bus_read_o ? ERR_DATA : 32'h0;
            if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
